// File: rtl/seg_codec_pkg.sv
// Shared 7-segment codec constants: segment patterns, digit selects and frame states.
package seg_codec_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = DIGITS * NIB_W;

  localparam logic [SEG_W-1:0] SEG_0 = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 8'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 8'h77;
  localparam logic [SEG_W-1:0] SEG_B = 8'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 8'h39;
  localparam logic [SEG_W-1:0] SEG_D = 8'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 8'h79;
  localparam logic [SEG_W-1:0] SEG_F = 8'h40;  // dash doubles as F

  localparam logic [DIGITS-1:0] CS_DIG0 = 4'b0001;
  localparam logic [DIGITS-1:0] CS_DIG1 = 4'b0010;
  localparam logic [DIGITS-1:0] CS_DIG2 = 4'b0100;
  localparam logic [DIGITS-1:0] CS_DIG3 = 4'b1000;

  typedef enum logic {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Exact-match decode of a 7-segment pattern back to its hex nibble.
module seg_pattern_decode
  import seg_codec_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [NIB_W-1:0] nibble,
  output logic             hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive 4-digit 7-segment scan receiver: reassembles and reports displayed 16-bit frames.
// Optional STABLE_FILTER_EN: publish a frame only when it repeats the previous complete frame.
module seg_scan_decoder
  import seg_codec_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIGITS-1:0] seg_cs,
  input  logic [SEG_W-1:0]  seg_data,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [DIGITS-1:0] cs_m, cs_s, cs_prev;
  logic [SEG_W-1:0]  sd_m, sd_s;
  logic [CNT_W-1:0]  cnt;
  logic              sample;
  logic [NIB_W-1:0]  nib;
  logic              hit;
  logic              digit_ok;
  logic [11:0]       part;
  logic [1:0]        idx;
  logic [WORD_W-1:0] frame_word;
  frame_state_t      state;

  // Two-flop synchronisers for the asynchronous scan bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_m <= '0;
      cs_s <= '0;
      sd_m <= '0;
      sd_s <= '0;
    end else begin
      cs_m <= seg_cs;
      cs_s <= cs_m;
      sd_m <= seg_data;
      sd_s <= sd_m;
    end
  end

  // Settle counter: restarts on every select change, saturates at SETTLE_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_prev <= '0;
      cnt     <= '0;
    end else begin
      cs_prev <= cs_s;
      if (cs_s != cs_prev)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign sample     = (cs_s == cs_prev) && (cnt == CNT_LAST);
  assign digit_ok   = (cs_s == DIGITS'(CS_DIG0 << idx));
  assign frame_word = {nib, part};

  seg_pattern_decode u_decode (
    .pattern (sd_s),
    .nibble  (nib),
    .hit     (hit)
  );

`ifdef STABLE_FILTER_EN
  logic [WORD_W-1:0] hist;
  logic              hist_vld;
`endif

  // Frame assembly state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      idx        <= 2'd0;
      part       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef STABLE_FILTER_EN
      hist       <= '0;
      hist_vld   <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample) begin
        case (state)
          HUNT: begin
            if (cs_s == CS_DIG0) begin
              if (hit) begin
                part[3:0] <= nib;
                idx       <= 2'd1;
                state     <= ASSEMBLE;
              end else begin
                frame_err <= 1'b1;
`ifdef STABLE_FILTER_EN
                hist_vld  <= 1'b0;
`endif
              end
            end
          end
          ASSEMBLE: begin
            if (hit && digit_ok) begin
              case (idx)
                2'd1:    part[7:4]  <= nib;
                2'd2:    part[11:8] <= nib;
                default: ;
              endcase
              if (idx == 2'd3) begin
                idx   <= 2'd0;
                state <= HUNT;
`ifdef STABLE_FILTER_EN
                if (hist_vld && (frame_word == hist)) begin
                  data_out   <= frame_word;
                  data_valid <= 1'b1;
                end
                hist     <= frame_word;
                hist_vld <= 1'b1;
`else
                data_out   <= frame_word;
                data_valid <= 1'b1;
`endif
              end else begin
                idx <= idx + 2'd1;
              end
            end else if (hit && (cs_s == CS_DIG0)) begin
              // Resync: a fresh digit0 restarts the frame in place
              frame_err <= 1'b1;
              part[3:0] <= nib;
              idx       <= 2'd1;
`ifdef STABLE_FILTER_EN
              hist_vld  <= 1'b0;
`endif
            end else begin
              frame_err <= 1'b1;
              idx       <= 2'd0;
              state     <= HUNT;
`ifdef STABLE_FILTER_EN
              hist_vld  <= 1'b0;
`endif
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder; expectations follow STABLE_FILTER_EN when defined.
module tb_seg_scan_decoder;

  localparam int HOLD = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  seg_cs;
  logic [7:0]  seg_data;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int exp_err  = 0;
  logic [15:0] exp_out = 16'h0000;
  logic [15:0] mh = 16'h0000;
  logic        mh_v = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_cs     (seg_cs),
    .seg_data   (seg_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 8'h3F; 4'h1: enc = 8'h06; 4'h2: enc = 8'h5B; 4'h3: enc = 8'h4F;
      4'h4: enc = 8'h66; 4'h5: enc = 8'h6D; 4'h6: enc = 8'h7D; 4'h7: enc = 8'h07;
      4'h8: enc = 8'h7F; 4'h9: enc = 8'h6F; 4'hA: enc = 8'h77; 4'hB: enc = 8'h7C;
      4'hC: enc = 8'h39; 4'hD: enc = 8'h5E; 4'hE: enc = 8'h79; default: enc = 8'h40;
    endcase
  endfunction

  // Reference model of what a complete frame should publish
  task automatic model_complete(input logic [15:0] v);
`ifdef STABLE_FILTER_EN
    if (mh_v && mh == v) begin
      exp_q.push_back(v);
      exp_out = v;
    end
    mh   = v;
    mh_v = 1'b1;
`else
    exp_q.push_back(v);
    exp_out = v;
`endif
  endtask

  task automatic model_err();
    exp_err++;
    mh_v = 1'b0;
  endtask

  task automatic drive(input logic [3:0] cs, input logic [7:0] d, input int n);
    seg_cs   = cs;
    seg_data = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic dig(input int i, input logic [15:0] v);
    logic [15:0] w;
    w = v;
    drive(4'(1 << i), enc(w[i*4 +: 4]), HOLD);
  endtask

  task automatic send_frame(input logic [15:0] v);
    model_complete(v);
    for (int i = 0; i < 4; i++) dig(i, v);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_err_cnt"}, 32'(err_seen), 32'(exp_err));
    check({tag, "_q_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'(exp_out));
  endtask

  // Output monitor: pops the scoreboard on each publish pulse
  always @(negedge clk) begin
    logic [31:0] e;
    if (data_valid) begin
      e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
      check("publish", 32'(data_out), e);
      check("dv_fe_excl", 32'(frame_err), 32'd0);
    end
    if (frame_err) err_seen++;
  end

  initial begin
    rst = 1'b1;
    seg_cs = 4'b0000;
    seg_data = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    end_checks("idle");

    send_frame(16'h1234);
    send_frame(16'h1234);
    end_checks("clean");
    send_frame(16'h5678);
    send_frame(16'h90EF);
    end_checks("digits");

    // Glitch select shorter than the settle window between digit0 and digit1
    model_complete(16'h1234);
    dig(0, 16'h1234);
    drive(4'b0100, enc(4'h2), 5);
    for (int i = 1; i < 4; i++) dig(i, 16'h1234);
    end_checks("glitch");

    // Undecodable pattern on digit2
    model_err();
    dig(0, 16'h1234);
    dig(1, 16'h1234);
    drive(4'b0100, 8'hFF, HOLD);
    check("miss_err_at_dig2", 32'(err_seen), 32'(exp_err));
    dig(3, 16'h1234);
    end_checks("miss");
    send_frame(16'h1234);
    end_checks("after_miss");

    // Skipped digit
    model_err();
    dig(0, 16'h4321);
    dig(2, 16'h4321);
    end_checks("skip");

    // Resync on an early digit0
    model_err();
    model_complete(16'h2468);
    dig(0, 16'h1357);
    dig(1, 16'h1357);
    for (int i = 0; i < 4; i++) dig(i, 16'h2468);
    end_checks("resync");

    // Stability filter sequence
    send_frame(16'hABCD);
    check("f1_data_out", 32'(data_out), 32'(exp_out));
    send_frame(16'hABCD);
    check("f2_data_out", 32'(data_out), 32'(exp_out));
    send_frame(16'hABCE);
    check("f3_data_out", 32'(data_out), 32'(exp_out));
    send_frame(16'hABCE);
    end_checks("filter");

    // Reset after the digit1 sample
    dig(0, 16'h9999);
    dig(1, 16'h9999);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    rst = 1'b0;
    mh_v = 1'b0;
    exp_out = 16'h0000;
    repeat (HOLD) @(negedge clk);
    end_checks("post_rst");
    send_frame(16'h5678);
    repeat (10) @(negedge clk);
    end_checks("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
